lsu_multicycle: RTL and testbench

//  Parametrised multi-cycle load/store unit; successor to the single-cycle LW/SW datapath in the top-level cpu.

---
 rtl/lsu_multicycle_if.sv | 45 ++++
 rtl/lsu_multicycle.sv | 103 ++++++++++
 tb/tb_lsu_multicycle.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_multicycle_if.sv
// Bus bundle between the load/store unit and its environment:
// issue port from the pipeline, data-memory req/valid port, and the
// register-file write port.
interface lsu_multicycle_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 4,
  parameter int REG_W  = 4
);
  logic              issue_valid;
  logic              issue_ready;
  logic              issue_is_store;
  logic [DATA_W-1:0] issue_base;
  logic [OFF_W-1:0]  issue_off;
  logic [DATA_W-1:0] issue_store_data;
  logic [REG_W-1:0]  issue_dst;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              wb_en;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              done;
  logic              stall;
  logic              err;

  // Environment side: pipeline issuing ops plus the data memory.
  modport master (
    output issue_valid, issue_is_store, issue_base, issue_off,
           issue_store_data, issue_dst, mem_rdata, mem_valid,
    input  issue_ready, mem_en, mem_wr, mem_addr, mem_wdata,
           wb_en, wb_reg, wb_data, done, stall, err
  );

  // Load/store unit side.
  modport slave (
    input  issue_valid, issue_is_store, issue_base, issue_off,
           issue_store_data, issue_dst, mem_rdata, mem_valid,
    output issue_ready, mem_en, mem_wr, mem_addr, mem_wdata,
           wb_en, wb_reg, wb_data, done, stall, err
  );
endinterface

// File: rtl/lsu_multicycle.sv
// Multi-cycle load/store unit: one LW/SW in flight, IDLE->REQ->WAIT->WB,
// variable-latency memory with a bounded wait and a sticky timeout flag.
module lsu_multicycle #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = 4,
  parameter int OFF_SHIFT = 1,
  parameter int REG_W     = 4,
  parameter int TIMEOUT   = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  lsu_multicycle_if.slave  io_bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  // Low base bits cleared so the offset scaling always lands aligned.
  localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'((64'd1 << OFF_SHIFT) - 64'd1);

  logic [1:0]        r_state;
  logic              r_is_store;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [REG_W-1:0]  r_dst;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic [DATA_W-1:0] w_off_sext;
  logic [DATA_W-1:0] w_eff_full;
  logic [ADDR_W-1:0] w_eff;
  logic              w_idle;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_off_sext = {{(DATA_W-OFF_W){io_bus.issue_off[OFF_W-1]}}, io_bus.issue_off};
  // Sum taken at full data width, truncated so the address wraps mod 2^ADDR_W.
  assign w_eff_full = (io_bus.issue_base & ~ALIGN_MASK) + (w_off_sext << OFF_SHIFT);
  assign w_eff      = w_eff_full[ADDR_W-1:0];

  // FSM plus operand latches; operands are frozen at accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dst      <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.issue_valid) begin
            r_is_store <= io_bus.issue_is_store;
            r_addr     <= w_eff;
            r_wdata    <= io_bus.issue_store_data;
            r_dst      <= io_bus.issue_dst;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A response on the final wait cycle still completes the op.
          if (io_bus.mem_valid) begin
            if (!r_is_store) r_rdata <= io_bus.mem_rdata;
            r_state <= ST_WB;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.issue_ready = w_idle;
  assign io_bus.stall       = ~w_idle;
  assign io_bus.mem_en      = (r_state == ST_REQ);
  assign io_bus.mem_wr      = (r_state == ST_REQ) & r_is_store;
  assign io_bus.mem_addr    = r_addr;
  assign io_bus.mem_wdata   = r_wdata;
  assign io_bus.done        = (r_state == ST_WB);
  assign io_bus.wb_en       = (r_state == ST_WB) & ~r_is_store;
  assign io_bus.wb_reg      = r_dst;
  assign io_bus.wb_data     = r_rdata;
  assign io_bus.err         = r_err;

endmodule

// File: tb/tb_lsu_multicycle.sv
// Directed bench for lsu_multicycle: memory model answers 4 cycles after
// mem_en unless muted; extra valid pulses can be injected by hand.
module tb_lsu_multicycle;
  logic clk = 1'b0;
  logic rst = 1'b1;

  lsu_multicycle_if #(.DATA_W(16), .ADDR_W(16), .OFF_W(4), .REG_W(4)) bus ();

  lsu_multicycle #(
    .DATA_W(16), .ADDR_W(16), .OFF_W(4), .OFF_SHIFT(1), .REG_W(4), .TIMEOUT(8)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        mem_mute  = 1'b0;
  logic        m_valid   = 1'b0;
  logic        late_vld  = 1'b0;
  logic [15:0] mem_data  = 16'h0;
  int          cd        = 0;

  assign bus.mem_valid = m_valid | late_vld;
  assign bus.mem_rdata = mem_data;

  // Memory model: one-cycle valid pulse four cycles after mem_en.
  always @(posedge clk) begin
    #1;
    m_valid = 1'b0;
    if (cd == 1) m_valid = 1'b1;
    if (cd > 0) cd = cd - 1;
    if (bus.mem_en && !mem_mute) cd = 4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic st, input logic [15:0] base, input logic [3:0] off,
                       input logic [15:0] wd, input logic [3:0] dst);
    bus.issue_valid      = 1'b1;
    bus.issue_is_store   = st;
    bus.issue_base       = base;
    bus.issue_off        = off;
    bus.issue_store_data = wd;
    bus.issue_dst        = dst;
  endtask

  // One full op with default memory latency; expectations given by caller.
  task automatic do_op(input string tag, input logic st, input logic [15:0] base,
                       input logic [3:0] off, input logic [15:0] wd, input logic [3:0] dst,
                       input logic [15:0] rd, input logic [15:0] exp_addr);
    mem_data = rd;
    issue(st, base, off, wd, dst);
    tick();                                   // t1
    bus.issue_valid = 1'b0;
    bus.issue_base  = 16'hAAAA;               // must be ignored
    bus.issue_store_data = 16'h5555;
    chk({tag, "_men"},   bus.mem_en, 1);
    chk({tag, "_mwr"},   bus.mem_wr, st);
    chk({tag, "_maddr"}, bus.mem_addr, exp_addr);
    if (st) chk({tag, "_mwdata"}, bus.mem_wdata, wd);
    chk({tag, "_busy"},  {bus.stall, bus.issue_ready}, 2'b10);
    for (int i = 0; i < 4; i++) begin         // t2..t5
      tick();
      chk({tag, "_wait"}, {bus.mem_en, bus.done, bus.wb_en, bus.stall}, 4'b0001);
    end
    tick();                                   // t6
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_wben"}, bus.wb_en, !st);
    if (!st) chk({tag, "_wbreg"},  bus.wb_reg, dst);
    if (!st) chk({tag, "_wbdata"}, bus.wb_data, rd);
    tick();                                   // t7
    chk({tag, "_idle"}, {bus.done, bus.wb_en, bus.issue_ready, bus.stall}, 4'b0010);
  endtask

  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_is_store = 1'b0;
    bus.issue_base = '0;
    bus.issue_off = '0;
    bus.issue_store_data = '0;
    bus.issue_dst = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", bus.issue_ready, 1);
    chk("rst_outs", {bus.stall, bus.mem_en, bus.mem_wr, bus.wb_en, bus.done, bus.err}, 6'b0);
    chk("rst_addr", bus.mem_addr, 16'h0);
    tick();

    do_op("lw",   1'b0, 16'h1001, 4'hF, 16'h0,    4'd3, 16'hBEEF, 16'h0FFE);
    do_op("sw",   1'b1, 16'h0020, 4'h3, 16'h1234, 4'd9, 16'h0,    16'h0026);
    do_op("wrap", 1'b0, 16'hFFFE, 4'h2, 16'h0,    4'd0, 16'h00A5, 16'h0002);

    // Valid on the last wait cycle beats the timeout.
    mem_mute = 1'b1;
    issue(1'b0, 16'h0300, 4'h0, 16'h0, 4'd6);
    tick();                                   // t1
    bus.issue_valid = 1'b0;
    repeat (8) tick();                        // t9, last WAIT
    chk("vw_stall", bus.stall, 1);
    mem_data = 16'h5A5A;
    late_vld = 1'b1;
    tick();                                   // t10
    late_vld = 1'b0;
    chk("vw_wb", {bus.wb_en, bus.done, bus.err}, 3'b110);
    chk("vw_data", bus.wb_data, 16'h5A5A);
    tick();

    // Timeout: never answered.
    issue(1'b0, 16'h0040, 4'h0, 16'h0, 4'd7);
    tick();                                   // t1
    bus.issue_valid = 1'b0;
    repeat (8) tick();                        // t9
    chk("to_notyet", {bus.err, bus.stall}, 2'b01);
    tick();                                   // t10
    chk("to_err", {bus.err, bus.issue_ready, bus.stall}, 3'b110);
    chk("to_nowb", {bus.done, bus.wb_en}, 2'b00);
    mem_data = 16'h7777;
    late_vld = 1'b1;
    tick();
    late_vld = 1'b0;
    chk("to_late", {bus.done, bus.wb_en, bus.stall, bus.err}, 4'b0001);
    tick();
    chk("to_late2", {bus.done, bus.wb_en, bus.stall}, 3'b000);
    mem_mute = 1'b0;

    do_op("sw2", 1'b1, 16'h0101, 4'h8, 16'h4321, 4'd1, 16'h0, 16'h00F0);
    chk("err_sticky", bus.err, 1);

    // Back-to-back with issue_valid held and operands changing.
    mem_data = 16'h1111;
    issue(1'b0, 16'h0100, 4'h0, 16'h0, 4'd5);
    tick();                                   // t1
    issue(1'b1, 16'h7770, 4'h1, 16'hDEAD, 4'd2);
    chk("b2b_frozen", bus.mem_addr, 16'h0100);
    for (int i = 0; i < 5; i++) begin         // t2..t6
      tick();
      issue(1'b1, 16'h7770 + 16'(i), 4'h1, 16'hDEAD, 4'd2);
    end
    chk("b2b_a_wb", {bus.wb_en, bus.wb_reg, bus.issue_ready}, {1'b1, 4'd5, 1'b0});
    chk("b2b_a_data", bus.wb_data, 16'h1111);
    tick();                                   // t7, ready
    chk("b2b_ready", bus.issue_ready, 1);
    issue(1'b1, 16'h0200, 4'h1, 16'hCAFE, 4'd2);
    tick();                                   // t8
    bus.issue_valid = 1'b0;
    chk("b2b_b_addr", bus.mem_addr, 16'h0202);
    chk("b2b_b_req", {bus.mem_en, bus.mem_wr}, 2'b11);
    chk("b2b_b_wdata", bus.mem_wdata, 16'hCAFE);
    begin
      int k = 0;
      while (!bus.done && k < 20) begin tick(); k++; end
      chk("b2b_b_done", bus.done, 1);
      chk("b2b_b_nowb", bus.wb_en, 0);
    end
    tick();

    // Reset mid-WAIT abandons the load and clears err.
    mem_data = 16'hDEAD;
    issue(1'b0, 16'h0500, 4'h0, 16'h0, 4'd4);
    tick();                                   // t1
    bus.issue_valid = 1'b0;
    tick(); tick();                           // t3
    rst = 1'b1;
    tick();                                   // t4
    rst = 1'b0;
    chk("mr_state", {bus.stall, bus.issue_ready, bus.err}, 3'b010);
    chk("mr_nowb", {bus.wb_en, bus.done}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_ignored", {bus.wb_en, bus.done, bus.stall}, 3'b000);
    end

    do_op("post", 1'b0, 16'h0010, 4'h2, 16'h0, 4'd8, 16'h0F0F, 16'h0014);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
